fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16: maximum consecutive cycles imem_req may stay high without imem_ack.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pc_next  input  32  next PC from the PC-select multiplexer (pc+4 or branch/jump target).
REQ-006 retire  input  1  core has consumed the current instruction; advance PC.
REQ-007 imem_ack  input  1  instruction memory returns data this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address, always equal to pc.
REQ-011 pc  output  32  current program counter; feeds the pc+4 and branch-target adders.
REQ-012 instr  output  32  latched instruction word.
REQ-013 instr_valid  output  1  instr is valid for decode.
REQ-014 fetch_fault  output  1  sticky fault flag.
REQ-015 fault_cause  output  2  00 none, 01 misaligned pc_next, 10 fetch timeout.

Function
REQ-016 States SHALL be S_REQ, S_VALID and S_FAULT.
REQ-017 S_REQ: imem_req=1, instr_valid=0, wait counter increments each cycle without ack.
REQ-018 S_REQ with imem_ack=1: instr<=imem_rdata, counter cleared, go to S_VALID; instr_valid=1 in the cycle after ack (latency 1).
REQ-019 S_REQ with no ack for TIMEOUT consecutive cycles: go to S_FAULT, fetch_fault=1, fault_cause=10, from the next cycle.
REQ-020 Ack in the same cycle the counter reaches its limit: ack wins, no fault.
REQ-021 S_VALID: imem_req=0, instr_valid=1, instr and pc held until retire=1.
REQ-022 S_VALID with retire=1 and pc_next[1:0]=00: pc<=pc_next, go to S_REQ, instr_valid=0 next cycle.
REQ-023 S_VALID with retire=1 and pc_next[1:0]!=00: pc<=pc_next (faulting address reported), go to S_FAULT, fault_cause=01.
REQ-024 S_FAULT: imem_req=0, instr_valid=0, pc/instr/fault_cause held; exit only by reset.
REQ-025 retire outside S_VALID and imem_ack outside S_REQ SHALL be ignored.
REQ-026 imem_addr SHALL equal pc combinationally in every state.
REQ-027 Counter width SHALL be $clog2(TIMEOUT+1); no wrap-around, because a fault is raised at the limit.

Reset
REQ-028 rst_n=0 at a clock edge SHALL override all other inputs and, in any state, set pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_fault=0, fault_cause=00, counter=0, state=S_REQ.
REQ-029 imem_req SHALL be forced to 0 while rst_n=0; the first request, to RESET_PC, SHALL issue in the first cycle after rst_n=1.
REQ-030 Reset during an outstanding request SHALL abandon it; a late imem_ack SHALL not be captured.

Structure
REQ-031 State encodings and fault_cause codes SHALL live in the shared core package/header (core_pkg) and be used by the control and trap logic.
REQ-032 The wait counter SHALL be a sub-module, fetch_timer (inputs: clk, rst_n, clear, enable; output: expired); everything else stays flat.

Verification
REQ-033 Reset release, ack 1 cycle after the request with rdata=32'h0000_0013 -> imem_addr=0, instr=32'h0000_0013, instr_valid=1 one cycle after ack.
REQ-034 In S_VALID, retire=1 with pc_next=32'h0000_0004 -> pc=4, imem_req=1 next cycle, instr_valid=0.
REQ-035 TIMEOUT=16, no ack for 16 cycles -> fetch_fault=1, fault_cause=10, imem_req=0; further acks are ignored.
REQ-036 retire=1 with pc_next=32'h0000_0102 -> pc=32'h0000_0102, fault_cause=01, no new request.
REQ-037 Ack in the 16th waiting cycle -> instr captured, fetch_fault stays 0.
REQ-038 rst_n=0 in S_VALID and in S_FAULT -> all outputs at reset values next edge; new fetch from RESET_PC after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encodings, fault cause codes and
// the instruction-alignment helper used by the fetch control and trap logic.
package core_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'b00,
    S_VALID = 2'b01,
    S_FAULT = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } fault_cause_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_timer.sv
// Wait counter for an outstanding fetch; expired flags the last cycle an
// un-acked request may stay pending. The count saturates instead of wrapping.
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count_r;

  // wait-cycle counter, cleared on ack/leave, saturating at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r >= LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request per PC, latches the returned
// word for decode, and traps on fetch timeout or a misaligned next PC.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc_next,
  input  logic               retire,
  fetch_unit_if.master       imem,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               fetch_fault,
  output logic [1:0]         fault_cause
);

  fetch_state_t state_r;
  fetch_state_t state_nx_s;
  fault_cause_t cause_r;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic         expired_s;
  logic         req_s;
  logic         valid_s;
  logic         fault_s;
  logic         timer_en_s;
  logic         timer_clr_s;

  // Timer only runs while a request is pending and unanswered.
  assign timer_en_s  = (state_r == S_REQ) && !imem.imem_ack;
  assign timer_clr_s = (state_r != S_REQ) || imem.imem_ack;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clr_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_REQ;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next-state logic; ack takes priority over the timeout
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_REQ: begin
        if (imem.imem_ack) begin
          state_nx_s = S_VALID;
        end else if (expired_s) begin
          state_nx_s = S_FAULT;
        end else begin
          state_nx_s = S_REQ;
        end
      end
      S_VALID: begin
        if (retire) begin
          state_nx_s = is_aligned(pc_next[1:0]) ? S_REQ : S_FAULT;
        end else begin
          state_nx_s = S_VALID;
        end
      end
      S_FAULT: state_nx_s = S_FAULT;
      default: state_nx_s = S_FAULT;
    endcase
  end

  // state-decoded outputs; the request is held low while reset is asserted
  always_comb begin
    req_s   = 1'b0;
    valid_s = 1'b0;
    fault_s = 1'b0;
    case (state_r)
      S_REQ:   req_s   = rst_n;
      S_VALID: valid_s = 1'b1;
      S_FAULT: fault_s = 1'b1;
      default: fault_s = 1'b1;
    endcase
  end

  // pc, instruction latch and fault cause
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      instr_r <= 32'h0000_0000;
      cause_r <= CAUSE_NONE;
    end else begin
      case (state_r)
        S_REQ: begin
          if (imem.imem_ack) begin
            instr_r <= imem.imem_rdata;
          end else if (expired_s) begin
            cause_r <= CAUSE_TIMEOUT;
          end else begin
            instr_r <= instr_r;
          end
        end
        S_VALID: begin
          if (retire) begin
            // the faulting target is kept in pc so the trap can report it
            pc_r <= pc_next;
            if (!is_aligned(pc_next[1:0])) begin
              cause_r <= CAUSE_MISALIGN;
            end else begin
              cause_r <= cause_r;
            end
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          pc_r    <= pc_r;
          instr_r <= instr_r;
          cause_r <= cause_r;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc_r;
  assign pc             = pc_r;
  assign instr          = instr_r;
  assign instr_valid    = valid_s;
  assign fetch_fault    = fault_s;
  assign fault_cause    = cause_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch, retire, timeout, ack-at-limit,
// misaligned target and reset from S_VALID / S_FAULT.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_next     (pc_next),
    .retire      (retire),
    .imem        (bus),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    retire         = 1'b0;
    pc_next        = 32'h0000_0000;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hdead_beef;
    tick(2);
    chk("rst_pc",    pc,                 32'h0000_0000);
    chk("rst_instr", instr,              32'h0000_0000);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_cause", {30'b0, fault_cause}, 32'd0);
    chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);

    // release: request to RESET_PC, ack one cycle later
    bus.imem_ack = 1'b0;
    rst_n        = 1'b1;
    #1;
    chk("rel_req",  {31'b0, bus.imem_req}, 32'd1);
    chk("rel_addr", bus.imem_addr,         32'h0000_0000);
    tick(1);
    chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0013;
    tick(1);
    bus.imem_ack = 1'b0;
    chk("cap_instr", instr,                 32'h0000_0013);
    chk("cap_valid", {31'b0, instr_valid},  32'd1);
    chk("cap_req",   {31'b0, bus.imem_req}, 32'd0);

    // ack while valid is ignored; instr held without retire
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0bad_0bad;
    tick(1);
    bus.imem_ack = 1'b0;
    chk("hold_instr", instr,                32'h0000_0013);
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);

    // retire to aligned pc 4
    retire  = 1'b1;
    pc_next = 32'h0000_0004;
    tick(1);
    retire = 1'b0;
    chk("ret_pc",    pc,                    32'h0000_0004);
    chk("ret_addr",  bus.imem_addr,         32'h0000_0004);
    chk("ret_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("ret_valid", {31'b0, instr_valid},  32'd0);

    // ack arriving in the 16th waiting cycle wins over the timeout
    tick(15);
    chk("w15_req",   {31'b0, bus.imem_req}, 32'd1);
    chk("w15_fault", {31'b0, fetch_fault},  32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    tick(1);
    bus.imem_ack = 1'b0;
    chk("lim_instr", instr,                32'h0050_0093);
    chk("lim_valid", {31'b0, instr_valid}, 32'd1);
    chk("lim_fault", {31'b0, fetch_fault}, 32'd0);
    chk("lim_cause", {30'b0, fault_cause}, 32'd0);

    // timeout: 16 cycles with no ack
    retire  = 1'b1;
    pc_next = 32'h0000_0008;
    tick(1);
    retire = 1'b0;
    chk("to_pc", pc, 32'h0000_0008);
    tick(15);
    chk("to15_fault", {31'b0, fetch_fault},  32'd0);
    chk("to15_req",   {31'b0, bus.imem_req}, 32'd1);
    tick(1);
    chk("to_fault", {31'b0, fetch_fault},  32'd1);
    chk("to_cause", {30'b0, fault_cause},  32'd2);
    chk("to_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("to_valid", {31'b0, instr_valid},  32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1111_1111;
    retire         = 1'b1;
    tick(2);
    bus.imem_ack = 1'b0;
    retire       = 1'b0;
    chk("flt_instr", instr,                32'h0050_0093);
    chk("flt_pc",    pc,                   32'h0000_0008);
    chk("flt_fault", {31'b0, fetch_fault}, 32'd1);

    // reset out of S_FAULT, new fetch from RESET_PC
    rst_n = 1'b0;
    tick(1);
    chk("rf_pc",    pc,                    32'h0000_0000);
    chk("rf_instr", instr,                 32'h0000_0000);
    chk("rf_fault", {31'b0, fetch_fault},  32'd0);
    chk("rf_cause", {30'b0, fault_cause},  32'd0);
    chk("rf_req",   {31'b0, bus.imem_req}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rf_rel_req", {31'b0, bus.imem_req}, 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0013;
    tick(1);
    bus.imem_ack = 1'b0;
    chk("rf_cap_valid", {31'b0, instr_valid}, 32'd1);

    // misaligned next pc traps with cause 01
    retire  = 1'b1;
    pc_next = 32'h0000_0102;
    tick(1);
    retire = 1'b0;
    chk("mis_pc",    pc,                    32'h0000_0102);
    chk("mis_cause", {30'b0, fault_cause},  32'd1);
    chk("mis_fault", {31'b0, fetch_fault},  32'd1);
    chk("mis_req",   {31'b0, bus.imem_req}, 32'd0);
    chk("mis_valid", {31'b0, instr_valid},  32'd0);

    // reset out of S_VALID
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0093;
    tick(1);
    bus.imem_ack = 1'b0;
    chk("rv_pre_valid", {31'b0, instr_valid}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("rv_valid", {31'b0, instr_valid},  32'd0);
    chk("rv_instr", instr,                 32'h0000_0000);
    chk("rv_req",   {31'b0, bus.imem_req}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rv_rel_addr", bus.imem_addr, 32'h0000_0000);

    // retire outside S_VALID is ignored
    retire  = 1'b1;
    pc_next = 32'h0000_0040;
    tick(1);
    retire = 1'b0;
    chk("ign_pc",  pc,                    32'h0000_0000);
    chk("ign_req", {31'b0, bus.imem_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
